// File: rtl/fetch_unit_pkg.sv
// Shared types and decode helpers for the instruction fetch front end.
package fetch_unit_pkg;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        DROP
    } fetch_state_t;

    localparam logic [6:0] OP_JAL = 7'b1101111;

    // J-type immediate (byte offset, bit 0 always zero) from instruction bits [31:12].
    function automatic logic [20:0] jal_imm(input logic [31:12] ibits);
        return {ibits[31], ibits[19:12], ibits[20], ibits[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch unit bus bundle: instruction-memory port, redirect input and decoder/ROB handshake.
interface fetch_unit_if #(
    parameter int WIDTH    = 32,
    parameter int IQ_DEPTH = 8
);
    logic                            mem_resp;
    logic [WIDTH-1:0]                mem_rdata;
    logic                            mem_read;
    logic [WIDTH-1:0]                mem_address;
    logic                            flush;
    logic [WIDTH-1:0]                flush_pc;
    logic                            out_valid;
    logic                            out_ready;
    logic [WIDTH-1:0]                out_instr;
    logic [WIDTH-1:0]                out_pc;
    logic                            out_pred_taken;
    logic [$clog2(IQ_DEPTH+1)-1:0]   count;

    modport master (
        input  mem_resp, mem_rdata, flush, flush_pc, out_ready,
        output mem_read, mem_address, out_valid, out_instr, out_pc, out_pred_taken, count
    );

    modport slave (
        output mem_resp, mem_rdata, flush, flush_pc, out_ready,
        input  mem_read, mem_address, out_valid, out_instr, out_pc, out_pred_taken, count
    );
endinterface

// File: rtl/fetch_unit_queue.sv
// Flushable circular FIFO holding fetched entries; flush beats same-cycle enqueue and dequeue.
module fetch_unit_queue #(
    parameter int  IQ_DEPTH = 8,
    parameter type entry_t  = logic [0:0]
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          i_flush,
    input  logic                          i_enq,
    input  entry_t                        i_enq_data,
    input  logic                          i_deq,
    output entry_t                        o_head,
    output logic                          o_valid,
    output logic [$clog2(IQ_DEPTH+1)-1:0] o_count
);
    localparam int PW = $clog2(IQ_DEPTH);
    localparam int CW = $clog2(IQ_DEPTH+1);

    entry_t          r_mem [IQ_DEPTH];
    logic [PW-1:0]   r_wr_ptr;
    logic [PW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_enq;
    logic            w_deq;

    assign o_valid = (r_count != '0);
    assign o_count = r_count;
    assign o_head  = r_mem[r_rd_ptr];
    assign w_enq   = i_enq && !i_flush;
    assign w_deq   = i_deq && o_valid && !i_flush;

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_mem[r_wr_ptr] <= i_enq_data;
        end
    end

    // Depth is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
            if (w_enq && !w_deq)      r_count <= r_count + CW'(1);
            else if (!w_enq && w_deq) r_count <= r_count - CW'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// In-order fetch front end: PC generation, single-outstanding I-mem requester, flushable queue.
// Optional static JAL prediction is enabled by defining FETCH_JAL_PREDICT_EN.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               IQ_DEPTH = 8,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h00000060)
) (
    input  logic         clk,
    input  logic         rst,
    fetch_unit_if.master bus
);
    localparam int            CW      = $clog2(IQ_DEPTH+1);
    localparam logic [CW-1:0] DEPTH_C = CW'(IQ_DEPTH);
`ifdef FETCH_JAL_PREDICT_EN
    localparam bit JAL_PREDICT = 1'b1;
`else
    localparam bit JAL_PREDICT = 1'b0;
`endif

    typedef struct packed {
        logic [WIDTH-1:0] pc;
        logic [WIDTH-1:0] instr;
        logic             pred_taken;
    } iq_entry_t;

    fetch_state_t     r_state;
    logic [WIDTH-1:0] r_fetch_pc;
    logic [WIDTH-1:0] r_req_addr;
    logic             r_mem_read;
    logic [CW-1:0]    w_count;
    logic [CW-1:0]    w_count_next;
    logic             w_valid;
    logic             w_deq;
    logic             w_enq;
    logic             w_take;
    logic [20:0]      w_jal_imm;
    logic [WIDTH-1:0] w_next_pc;
    iq_entry_t        w_enq_data;
    iq_entry_t        w_head;

    assign w_jal_imm    = jal_imm(bus.mem_rdata[31:12]);
    assign w_take       = JAL_PREDICT && (bus.mem_rdata[6:0] == OP_JAL);
    assign w_next_pc    = w_take ? r_req_addr + {{(WIDTH-21){w_jal_imm[20]}}, w_jal_imm}
                                 : r_req_addr + WIDTH'(4);
    assign w_enq        = (r_state == REQ) && bus.mem_resp && !bus.flush;
    assign w_deq        = w_valid && bus.out_ready;
    // Only consulted on an accepted response, where flush is known low.
    assign w_count_next = w_count + CW'(1) - CW'(w_deq);
    assign w_enq_data   = '{pc: r_req_addr, instr: bus.mem_rdata, pred_taken: w_take};

    fetch_unit_queue #(
        .IQ_DEPTH (IQ_DEPTH),
        .entry_t  (iq_entry_t)
    ) u_queue (
        .clk        (clk),
        .rst        (rst),
        .i_flush    (bus.flush),
        .i_enq      (w_enq),
        .i_enq_data (w_enq_data),
        .i_deq      (w_deq),
        .o_head     (w_head),
        .o_valid    (w_valid),
        .o_count    (w_count)
    );

    assign bus.mem_read       = r_mem_read;
    assign bus.mem_address    = r_req_addr;
    assign bus.out_valid      = w_valid;
    assign bus.out_pc         = w_head.pc;
    assign bus.out_instr      = w_head.instr;
    assign bus.out_pred_taken = w_valid && w_head.pred_taken;
    assign bus.count          = w_count;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= RESET_PC;
            r_mem_read <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (bus.flush) begin
                        r_fetch_pc <= bus.flush_pc;
                    end else if (w_count < DEPTH_C) begin
                        r_req_addr <= r_fetch_pc;
                        r_state    <= REQ;
                        r_mem_read <= 1'b1;
                    end
                end
                REQ: begin
                    if (bus.flush) begin
                        // A response arriving with the flush is simply dropped.
                        r_fetch_pc <= bus.flush_pc;
                        r_state    <= bus.mem_resp ? IDLE : DROP;
                        r_mem_read <= !bus.mem_resp;
                    end else if (bus.mem_resp) begin
                        r_fetch_pc <= w_next_pc;
                        if (w_count_next < DEPTH_C) begin
                            r_req_addr <= w_next_pc;
                        end else begin
                            r_state    <= IDLE;
                            r_mem_read <= 1'b0;
                        end
                    end
                end
                DROP: begin
                    if (bus.flush) r_fetch_pc <= bus.flush_pc;
                    if (bus.mem_resp) begin
                        r_state    <= IDLE;
                        r_mem_read <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    r_mem_read <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: memory responder, queue-level reference model and directed scenarios.
module tb_fetch_unit;
    localparam int          WIDTH    = 32;
    localparam int          IQ_DEPTH = 8;
    localparam logic [31:0] RESET_PC = 32'h00000060;
`ifdef FETCH_JAL_PREDICT_EN
    localparam bit          PREDICT_ON = 1'b1;
`else
    localparam bit          PREDICT_ON = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        pred;
    } ent_t;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    fetch_unit_if #(.WIDTH(WIDTH), .IQ_DEPTH(IQ_DEPTH)) bus ();

    fetch_unit #(
        .WIDTH    (WIDTH),
        .IQ_DEPTH (IQ_DEPTH),
        .RESET_PC (RESET_PC)
    ) dut (
        .clk (clk),
        .rst (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_pass   = 0;
    ent_t        exp_q[$];
    logic [31:0] exp_next = RESET_PC;
    bit          taint    = 1'b0;
    int          n_enq    = 0;
    bit          mem_active = 1'b0;
    int          mem_wait   = 0;
    int          mem_lat    = 1;
    logic [31:0] mem_cur    = '0;
    bit          mem_plain  = 1'b1;
    bit          mem_jal    = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rst_n = 1'b0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    task automatic wait_read(input string name);
        for (int i = 0; i < 20 && !bus.mem_read; i++) step();
        chk(name, 32'(bus.mem_read), 32'd1);
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (mem_jal && a == 32'h60) return 32'h1000006F;
        if (mem_plain) return 32'h00000013;
        return {a[23:0], 8'h13};
    endfunction

    // Sequential next fetch, or the JAL target when prediction is built in.
    function automatic logic [31:0] model_next(input logic [31:0] pc, input logic [31:0] w,
                                               output bit pred);
        logic [31:0] imm;
        imm  = {{11{w[31]}}, w[31], w[19:12], w[20], w[30:21], 1'b0};
        pred = PREDICT_ON && (w[6:0] == 7'b1101111);
        return pred ? pc + imm : pc + 32'd4;
    endfunction

    // Reference model: queue contents and expected next request address.
    always @(posedge clk) begin
        if (!rst_n) begin
            exp_q.delete();
            exp_next = RESET_PC;
            taint    = 1'b0;
            n_enq    = 0;
        end else begin
            bit          deq;
            bit          p;
            logic [31:0] nx;
            deq = (exp_q.size() != 0) && bus.out_ready && !bus.flush;
            if (bus.flush) exp_q.delete();
            else if (deq) void'(exp_q.pop_front());
            if (bus.mem_resp) begin
                if (!bus.flush && !taint) begin
                    nx = model_next(mem_cur, bus.mem_rdata, p);
                    exp_q.push_back('{pc: mem_cur, instr: bus.mem_rdata, pred: p});
                    exp_next = nx;
                    n_enq++;
                end
                taint = 1'b0;
            end
            if (bus.flush) begin
                exp_next = bus.flush_pc;
                if (mem_active && !bus.mem_resp) taint = 1'b1;
            end
        end
    end

    // Memory responder plus per-cycle comparison against the model.
    always @(negedge clk) begin
        if (!rst_n) begin
            mem_active    = 1'b0;
            mem_wait      = 0;
            bus.mem_resp  = 1'b0;
            bus.mem_rdata = '0;
        end else begin
            if (bus.mem_resp) mem_active = 1'b0;
            bus.mem_resp = 1'b0;
            chk("out_valid", 32'(bus.out_valid), 32'(exp_q.size() != 0));
            chk("count", 32'(bus.count), 32'(exp_q.size()));
            if (exp_q.size() != 0) begin
                chk("out_pc", bus.out_pc, exp_q[0].pc);
                chk("out_instr", bus.out_instr, exp_q[0].instr);
                chk("out_pred", 32'(bus.out_pred_taken), 32'(exp_q[0].pred));
            end
            if (mem_active) chk("mem_read_held", 32'(bus.mem_read), 32'd1);
            if (bus.mem_read) begin
                if (!mem_active) begin
                    mem_active = 1'b1;
                    mem_wait   = 0;
                    mem_cur    = bus.mem_address;
                    chk("req_addr", bus.mem_address, exp_next);
                end else begin
                    chk("addr_stable", bus.mem_address, mem_cur);
                end
                mem_wait++;
                if (mem_wait >= mem_lat) begin
                    bus.mem_resp  = 1'b1;
                    bus.mem_rdata = mem_word(mem_cur);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n0;
        logic [31:0] t6_addr;
        bit          t6_pred;
        bus.flush     = 1'b0;
        bus.flush_pc  = '0;
        bus.out_ready = 1'b1;
        rst_n = 1'b0;
        repeat (3) step();
        chk("rst_mem_read", 32'(bus.mem_read), 32'd0);
        chk("rst_mem_address", bus.mem_address, 32'h60);
        chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
        chk("rst_count", 32'(bus.count), 32'd0);
        chk("rst_pred", 32'(bus.out_pred_taken), 32'd0);

        // First fetches: 1-cycle memory answering 0x13.
        rst_n = 1'b1;
        step();
        chk("t1_first_read", 32'(bus.mem_read), 32'd1);
        chk("t1_first_addr", bus.mem_address, 32'h60);
        step();
        chk("t1_second_addr", bus.mem_address, 32'h64);
        chk("t1_head_pc", bus.out_pc, 32'h60);
        chk("t1_head_instr", bus.out_instr, 32'h13);
        step();
        chk("t1_third_addr", bus.mem_address, 32'h68);

        // Async reset mid-request, then fill the queue with out_ready low.
        chk("t2_pre_rst_read", 32'(bus.mem_read), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t2_async_rst_read", 32'(bus.mem_read), 32'd0);
        chk("t2_async_rst_valid", 32'(bus.out_valid), 32'd0);
        mem_plain     = 1'b0;
        bus.out_ready = 1'b0;
        step();
        step();
        rst_n = 1'b1;
        repeat (20) step();
        chk("t2_enq_count", 32'(n_enq), 32'd8);
        chk("t2_full_count", 32'(bus.count), 32'd8);
        chk("t2_full_read", 32'(bus.mem_read), 32'd0);
        chk("t2_full_head", bus.out_pc, 32'h60);
        bus.out_ready = 1'b1;
        step();
        bus.out_ready = 1'b0;
        wait_read("t2_refetch_read");
        chk("t2_refetch_addr", bus.mem_address, 32'h80);

        // Flush while a slow request to 0x70 is outstanding.
        reset_dut();
        mem_lat       = 3;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 80; i++) begin
            if (bus.mem_read && bus.mem_address == 32'h70 && mem_wait == 1) break;
            step();
        end
        chk("t3_reach_0x70", bus.mem_address, 32'h70);
        bus.flush    = 1'b1;
        bus.flush_pc = 32'h200;
        step();
        bus.flush = 1'b0;
        chk("t3_flush_count", 32'(bus.count), 32'd0);
        chk("t3_drop_read", 32'(bus.mem_read), 32'd1);
        chk("t3_drop_addr", bus.mem_address, 32'h70);
        step();
        chk("t3_drop_addr2", bus.mem_address, 32'h70);
        step();
        wait_read("t3_redirect_read");
        chk("t3_redirect_addr", bus.mem_address, 32'h200);
        for (int i = 0; i < 20 && !bus.out_valid; i++) step();
        chk("t3_first_head", bus.out_pc, 32'h200);

        // Flush, response and dequeue in the same cycle.
        reset_dut();
        mem_lat       = 2;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (bus.mem_resp && bus.count >= 2) break;
            step();
        end
        chk("t4_setup", 32'(bus.mem_resp && bus.count >= 2), 32'd1);
        n0            = n_enq;
        bus.flush     = 1'b1;
        bus.flush_pc  = 32'h300;
        bus.out_ready = 1'b1;
        step();
        bus.flush     = 1'b0;
        bus.out_ready = 1'b0;
        chk("t4_count_zero", 32'(bus.count), 32'd0);
        chk("t4_valid_zero", 32'(bus.out_valid), 32'd0);
        chk("t4_no_enq", 32'(n_enq), 32'(n0));
        wait_read("t4_redirect_read");
        chk("t4_redirect_addr", bus.mem_address, 32'h300);

        // Pointer wrap: alternating out_ready, 20 in-order dequeues.
        reset_dut();
        mem_lat = 1;
        k = 0;
        for (int i = 0; i < 300 && k < 20; i++) begin
            bus.out_ready = (i % 2 == 1);
            if (bus.out_valid && bus.out_ready) begin
                chk("t5_seq_pc", bus.out_pc, 32'h60 + 32'(4 * k));
                k++;
            end
            step();
        end
        bus.out_ready = 1'b0;
        chk("t5_deq_total", 32'(k), 32'd20);

        // JAL +0x100 at 0x60.
        mem_jal = 1'b1;
        reset_dut();
        for (int i = 0; i < 20 && !bus.out_valid; i++) step();
        t6_addr = PREDICT_ON ? 32'h160 : 32'h64;
        t6_pred = PREDICT_ON;
        chk("t6_head_pc", bus.out_pc, 32'h60);
        chk("t6_head_instr", bus.out_instr, 32'h1000006F);
        chk("t6_next_addr", bus.mem_address, t6_addr);
        chk("t6_pred", 32'(bus.out_pred_taken), 32'(t6_pred));
        step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
